// File: rtl/seq_pattern_tx_if.sv
// Bus bundle for seq_pattern_tx: transfer request inputs and serial stream outputs.
// The master drives requests; the slave (the transmitter) drives the stream.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic [CNT_W-1:0] gap_in;
  logic             abort;
  logic             data_out;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pat_in, rep_in, gap_in, abort,
    input  data_out, bit_valid, busy, done
  );

  modport slave (
    input  start, pat_in, rep_in, gap_in, abort,
    output data_out, bit_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB first, rep times,
// with optional zero gaps between repetitions and a done pulse at completion.
module seq_pattern_tx #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gapCnt_q, gapCnt_d;
  logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
  logic             dataOut_q, dataOut_d;
  logic             bitValid_q, bitValid_d;
  logic             done_q, done_d;

  // shift_q[PAT_W-1] is the bit on data_out; bitIdx_q counts bits still to follow it.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    shift_d    = shift_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gapCnt_d   = gapCnt_q;
    bitIdx_d   = bitIdx_q;
    dataOut_d  = 1'b0;
    bitValid_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.rep_in != '0) && !bus.abort) begin
          pat_d      = bus.pat_in;
          rep_d      = bus.rep_in;
          gap_d      = bus.gap_in;
          shift_d    = bus.pat_in;
          bitIdx_d   = IDX_W'(PAT_W - 1);
          dataOut_d  = bus.pat_in[PAT_W-1];
          bitValid_d = 1'b1;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
          rep_d   = '0;
        end else if (bitIdx_q != '0) begin
          bitIdx_d   = bitIdx_q - IDX_W'(1);
          shift_d    = shift_q << 1;
          dataOut_d  = shift_q[PAT_W-2];
          bitValid_d = 1'b1;
        end else if (rep_q == CNT_W'(1)) begin
          state_d = IDLE;
          rep_d   = '0;
          done_d  = 1'b1;
        end else begin
          rep_d = rep_q - CNT_W'(1);
          if (gap_q == '0) begin
            shift_d    = pat_q;
            bitIdx_d   = IDX_W'(PAT_W - 1);
            dataOut_d  = pat_q[PAT_W-1];
            bitValid_d = 1'b1;
          end else begin
            gapCnt_d = gap_q;
            state_d  = GAP;
          end
        end
      end

      GAP: begin
        if (bus.abort) begin
          state_d  = IDLE;
          rep_d    = '0;
          gapCnt_d = '0;
        end else if (gapCnt_q == CNT_W'(1)) begin
          gapCnt_d   = '0;
          shift_d    = pat_q;
          bitIdx_d   = IDX_W'(PAT_W - 1);
          dataOut_d  = pat_q[PAT_W-1];
          bitValid_d = 1'b1;
          state_d    = SEND;
        end else begin
          gapCnt_d = gapCnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      shift_q    <= '0;
      rep_q      <= '0;
      gap_q      <= '0;
      gapCnt_q   <= '0;
      bitIdx_q   <= '0;
      dataOut_q  <= 1'b0;
      bitValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      shift_q    <= shift_d;
      rep_q      <= rep_d;
      gap_q      <= gap_d;
      gapCnt_q   <= gapCnt_d;
      bitIdx_q   <= bitIdx_d;
      dataOut_q  <= dataOut_d;
      bitValid_q <= bitValid_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out  = dataOut_q;
  assign bus.bit_valid = bitValid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx with hand-computed bit streams
// and a small overlapping 10110 detector model fed from the serial output.
module tb_seq_pattern_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compareCount = 0;
  int   failCount = 0;
  int   detCount = 0;
  logic [3:0] hist = '0;

  seq_pattern_tx_if #(.PAT_W(5), .CNT_W(4)) bus ();

  seq_pattern_tx #(.PAT_W(5), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [4:0] p, input logic [3:0] r,
                               input logic [3:0] g, input logic a);
    bus.start  = s;
    bus.pat_in = p;
    bus.rep_in = r;
    bus.gap_in = g;
    bus.abort  = a;
  endtask

  // Advance one edge, sample after it, and feed valid bits to the detector model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.bit_valid === 1'b1) begin
      if ({hist, bus.data_out} == 5'b10110) detCount++;
      hist = {hist[2:0], bus.data_out};
    end
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic d, input logic v,
                             input logic b, input logic dn);
    checkValue({tag, ".data_out"},  int'(bus.data_out),  int'(d));
    checkValue({tag, ".bit_valid"}, int'(bus.bit_valid), int'(v));
    checkValue({tag, ".busy"},      int'(bus.busy),      int'(b));
    checkValue({tag, ".done"},      int'(bus.done),      int'(dn));
  endtask

  initial begin
    logic [9:0] stream;
    logic [4:0] pat2;
    int         busyCycles;
    int         doneCount;

    stream = 10'b1011010110;
    applyStimulus(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Start during reset must be ignored (reset has priority)
    applyStimulus(1'b1, 5'b10110, 4'd2, 4'd0, 1'b0);
    tick();
    checkOutput("rst_prio", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 5'b10110, 4'd2, 4'd0, 1'b0);
    tick();
    checkOutput("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // rep=2 gap=0: back-to-back 10110 10110, detector sees two hits
    hist = '0;
    detCount = 0;
    applyStimulus(1'b1, 5'b10110, 4'd2, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) applyStimulus(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
      checkOutput($sformatf("g0_bit%0d", i), stream[9-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    checkOutput("g0_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("g0_after", 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("g0_detector", detCount, 2);

    // rep=2 gap=2: two zero cycles between repetitions, done on cycle 13
    busyCycles = 0;
    applyStimulus(1'b1, 5'b10110, 4'd2, 4'd2, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 1) applyStimulus(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
      if (bus.busy === 1'b1) busyCycles++;
      if (i <= 5)
        checkOutput($sformatf("g2_c%0d", i), stream[10-i], 1'b1, 1'b1, 1'b0);
      else if (i <= 7)
        checkOutput($sformatf("g2_c%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
      else if (i <= 12)
        checkOutput($sformatf("g2_c%0d", i), stream[12-i], 1'b1, 1'b1, 1'b0);
      else
        checkOutput("g2_done", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkValue("g2_busy_cycles", busyCycles, 12);

    // rep=3 abort on the 3rd valid bit
    applyStimulus(1'b1, 5'b10110, 4'd3, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) applyStimulus(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
      checkOutput($sformatf("ab_bit%0d", i), stream[9-i], 1'b1, 1'b1, 1'b0);
    end
    bus.abort = 1'b1;
    tick();
    checkOutput("ab_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.abort = 1'b0;
    tick();
    checkOutput("ab_stay", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort in IDLE blocks a simultaneous start
    applyStimulus(1'b1, 5'b10110, 4'd2, 4'd0, 1'b1);
    tick();
    checkOutput("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart mid-transfer with new inputs: ignored, latched values unchanged
    doneCount = 0;
    applyStimulus(1'b1, 5'b10110, 4'd2, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) applyStimulus(1'b1, 5'b01001, 4'd1, 4'd3, 1'b0);
      else applyStimulus(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
      checkOutput($sformatf("rs_bit%0d", i), stream[9-i], 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done === 1'b1) doneCount++;
      if (i > 0) checkOutput($sformatf("rs_idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkValue("rs_done_count", doneCount, 1);

    // rep=0: ignored
    applyStimulus(1'b1, 5'b11111, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rep0_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // rst on the 4th bit discards the transfer; a new start works normally
    applyStimulus(1'b1, 5'b10110, 4'd2, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) applyStimulus(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
      checkOutput($sformatf("rr_bit%0d", i), stream[9-i], 1'b1, 1'b1, 1'b0);
    end
    rst = 1'b1;
    tick();
    checkOutput("rr_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("rr_nodone", 1'b0, 1'b0, 1'b0, 1'b0);
    pat2 = 5'b11001;
    applyStimulus(1'b1, pat2, 4'd1, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) applyStimulus(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
      checkOutput($sformatf("rr_new%0d", i), pat2[4-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    checkOutput("rr_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("rr_after", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PAT_W, default 5, sets the pattern width in bits.
REQ-002 Parameter CNT_W, default 4, sets the width of the repeat and gap counters.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset; sampled on the rising edge of clk.
REQ-005 Port start, input, 1, request to transmit; sampled in IDLE only.
REQ-006 Port pat_in, input, PAT_W, pattern to serialize, sent MSB first; latched at accept.
REQ-007 Port rep_in, input, CNT_W, number of pattern repetitions; latched at accept.
REQ-008 Port gap_in, input, CNT_W, idle-zero cycles between repetitions; latched at accept.
REQ-009 Port abort, input, 1, terminates a transfer in progress.
REQ-010 Port data_out, output, 1, serial bit stream, registered; drives a sequence detector's data_in.
REQ-011 Port bit_valid, output, 1, high when data_out carries a pattern bit, registered.
REQ-012 Port busy, output, 1, high in SEND or GAP state.
REQ-013 Port done, output, 1, one-cycle pulse after the final bit of a completed transfer.

Function
REQ-014 The block SHALL implement states IDLE, SEND and GAP.
REQ-015 In IDLE, start=1 with rep_in!=0 and abort=0 SHALL be accepted, latching pat_in, rep_in and gap_in.
REQ-016 In IDLE, start with rep_in=0 SHALL be ignored, with no bits sent and no done pulse.
REQ-017 The first bit, pat_in[PAT_W-1], SHALL appear on data_out with bit_valid=1 in the cycle after acceptance (latency 1).
REQ-018 In SEND, one bit SHALL be output per cycle, MSB to LSB, for PAT_W consecutive cycles per repetition.
REQ-019 After the LSB of a non-final repetition with gap=0, the next cycle SHALL carry the MSB of the next repetition, with no bubble.
REQ-020 After the LSB of a non-final repetition with gap=G>0, the block SHALL enter GAP for exactly G cycles with data_out=0 and bit_valid=0, then resume SEND.
REQ-021 After the LSB of the final repetition, the next cycle SHALL be IDLE with done=1, data_out=0, bit_valid=0 and busy=0.
REQ-022 A transfer SHALL emit exactly rep*PAT_W valid bits; the repeat counter SHALL count down and must not wrap.
REQ-023 start while busy SHALL be ignored, and latched values SHALL be unaffected by input changes mid-transfer.
REQ-024 abort=1 in SEND or GAP SHALL force IDLE on the next cycle with data_out=0, bit_valid=0, busy=0 and done=0.
REQ-025 abort=1 in IDLE SHALL block acceptance of a simultaneous start.
REQ-026 Outside SEND, data_out SHALL be 0.
REQ-027 done SHALL never be high for two consecutive cycles.

Reset
REQ-028 rst=1 SHALL force IDLE and clear data_out, bit_valid, busy, done and all counters on the next edge.
REQ-029 rst SHALL take priority over start and abort.
REQ-030 rst asserted mid-transfer SHALL discard the transfer without a done pulse.

Verification
REQ-031 pat=5'b10110, rep=2, gap=0: data_out is 1,0,1,1,0,1,0,1,1,0 with bit_valid high for 10 cycles, then done=1 for one cycle. A chained overlapping 10110 Mealy detector pulses twice.
REQ-032 pat=10110, rep=2, gap=2: the stream is 10110, then 00 with bit_valid=0, then 10110; busy is high for 12 cycles; done appears on cycle 13 after acceptance.
REQ-033 pat=10110, rep=3, abort asserted on the 3rd valid bit: the output is 1,0,1, then IDLE with done=0 and busy=0.
REQ-034 start pulsed with rep=1 during an active rep=2 transfer: the second start is ignored, and exactly 10 bits are followed by a single done.
REQ-035 start with rep_in=0: the block stays IDLE with no bit_valid and no done.
REQ-036 rst asserted on the 4th bit of a transfer: all outputs are 0 on the next cycle; a new start is then accepted normally.
